// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store to req/ack data-bus controller with pipeline stall
// Ports: clk/reset; load_MEM, store_MEM, addr_MEM, wdata_MEM, size_MEM, sign_MEM from the MEM stage;
// mem_stall_MEM, rdata_MEM, addr_err_MEM, bus_err_MEM back to the pipeline/HCU;
// bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_rdata, bus_ack on the data bus.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_MEM,
  input  logic        store_MEM,
  input  logic [31:0] addr_MEM,
  input  logic [31:0] wdata_MEM,
  input  logic [1:0]  size_MEM,
  input  logic        sign_MEM,
  output logic        mem_stall_MEM,
  output logic [31:0] rdata_MEM,
  output logic        addr_err_MEM,
  output logic        bus_err_MEM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0] size_q, lo_q;
  logic sign_q, access, timeout;
  logic [3:0] be;
  logic [31:0] wd, ext;
  logic [7:0] rb;
  logic [15:0] rh;
  assign addr_err_MEM = (load_MEM | store_MEM) &
    ((size_MEM == 2'd3) | ((size_MEM == 2'd1) & addr_MEM[0]) | ((size_MEM == 2'd2) & (addr_MEM[1:0] != 2'b00)));
  assign access = (load_MEM | store_MEM) & ~addr_err_MEM;
  // Dropping the stall in DONE lets the pipeline advance on the DONE->IDLE edge.
  assign mem_stall_MEM = access & (state != DONE);
  assign timeout = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
  assign be = size_MEM == 2'd0 ? 4'b0001 << addr_MEM[1:0] :
              size_MEM == 2'd1 ? (addr_MEM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd = size_MEM == 2'd0 ? {4{wdata_MEM[7:0]}} :
              size_MEM == 2'd1 ? {2{wdata_MEM[15:0]}} : wdata_MEM;
  // Load lane selection uses the size/sign/offset captured at request time.
  assign rb = bus_rdata[{lo_q, 3'b000} +: 8];
  assign rh = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  assign ext = size_q == 2'd0 ? {{24{sign_q & rb[7]}}, rb} :
               size_q == 2'd1 ? {{16{sign_q & rh[15]}}, rh} : bus_rdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (access ? REQ : IDLE) :
               state == REQ  ? ((bus_ack | timeout) ? DONE : REQ) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      rdata_MEM   <= '0;
      bus_err_MEM <= 1'b0;
      cnt         <= '0;
      size_q      <= '0;
      lo_q        <= '0;
      sign_q      <= 1'b0;
    end else if (state == IDLE) begin
      if (access) begin
        bus_req   <= 1'b1;
        bus_we    <= store_MEM;
        bus_addr  <= {addr_MEM[31:2], 2'b00};
        bus_be    <= be;
        bus_wdata <= wd;
        size_q    <= size_MEM;
        lo_q      <= addr_MEM[1:0];
        sign_q    <= sign_MEM;
      end
    end else if (state == REQ) begin
      if (bus_ack) begin
        bus_req   <= 1'b0;
        rdata_MEM <= bus_we ? 32'd0 : ext;
      end else if (timeout) begin
        bus_req     <= 1'b0;
        rdata_MEM   <= '0;
        bus_err_MEM <= 1'b1;
      end else cnt <= cnt + 1'b1;
    end else begin
      cnt         <= '0;
      bus_err_MEM <= 1'b0;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table-driven and sequence checks for mem_access_unit
module tb_mem_access_unit;
  logic clk = 0, reset = 1;
  logic load_MEM = 0, store_MEM = 0, sign_MEM = 0, bus_ack = 0;
  logic [31:0] addr_MEM = 0, wdata_MEM = 0, bus_rdata = 0;
  logic [1:0] size_MEM = 0;
  logic mem_stall_MEM, addr_err_MEM, bus_err_MEM, bus_req, bus_we;
  logic [31:0] rdata_MEM, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  int total = 0, passed = 0;
  mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .load_MEM(load_MEM), .store_MEM(store_MEM),
    .addr_MEM(addr_MEM), .wdata_MEM(wdata_MEM), .size_MEM(size_MEM), .sign_MEM(sign_MEM),
    .mem_stall_MEM(mem_stall_MEM), .rdata_MEM(rdata_MEM), .addr_err_MEM(addr_err_MEM),
    .bus_err_MEM(bus_err_MEM), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack));
  always #5 clk = ~clk;
  typedef struct {
    logic ld, st;
    logic [31:0] addr, wd;
    logic [1:0] sz;
    logic sg;
    logic [31:0] rd;
    logic err;
    logic [3:0] be;
    logic [31:0] ewd, erd;
  } vec_t;
  vec_t v[11];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  initial begin
    int n;
    logic ok;
    v[0]  = '{1, 0, 32'h100, 32'h0,        2'd2, 0, 32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF};
    v[1]  = '{1, 0, 32'h103, 32'h0,        2'd0, 1, 32'h80123456, 0, 4'b1000, 32'h0,        32'hFFFFFF80};
    v[2]  = '{1, 0, 32'h103, 32'h0,        2'd0, 0, 32'h80123456, 0, 4'b1000, 32'h0,        32'h00000080};
    v[3]  = '{1, 0, 32'h002, 32'h0,        2'd1, 1, 32'h80011234, 0, 4'b1100, 32'h0,        32'hFFFF8001};
    v[4]  = '{1, 0, 32'h000, 32'h0,        2'd1, 0, 32'h1234F00D, 0, 4'b0011, 32'h0,        32'h0000F00D};
    v[5]  = '{0, 1, 32'h301, 32'h000000A5, 2'd0, 0, 32'h55555555, 0, 4'b0010, 32'hA5A5A5A5, 32'h0};
    v[6]  = '{0, 1, 32'h400, 32'h12345678, 2'd2, 0, 32'h99999999, 0, 4'b1111, 32'h12345678, 32'h0};
    v[7]  = '{1, 0, 32'h101, 32'h0,        2'd2, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0};
    v[8]  = '{1, 0, 32'h203, 32'h0,        2'd1, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0};
    v[9]  = '{1, 0, 32'h000, 32'h0,        2'd3, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0};
    v[10] = '{1, 0, 32'h101, 32'h0,        2'd0, 1, 32'h00007F00, 0, 4'b0010, 32'h0,        32'h0000007F};
    step;
    chk("rst_req", {31'd0, bus_req}, 0);
    chk("rst_stall", {31'd0, mem_stall_MEM}, 0);
    chk("rst_rdata", rdata_MEM, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_be", {28'd0, bus_be}, 0);
    chk("rst_err", {31'd0, bus_err_MEM}, 0);
    reset = 0;
    step;
    for (int i = 0; i < 11; i++) begin
      load_MEM = v[i].ld; store_MEM = v[i].st; addr_MEM = v[i].addr; wdata_MEM = v[i].wd;
      size_MEM = v[i].sz; sign_MEM = v[i].sg;
      #1;
      chk($sformatf("v%0d_addr_err", i), {31'd0, addr_err_MEM}, {31'd0, v[i].err});
      chk($sformatf("v%0d_stall_idle", i), {31'd0, mem_stall_MEM}, {31'd0, ~v[i].err});
      step;
      if (v[i].err) begin
        chk($sformatf("v%0d_no_req", i), {31'd0, bus_req}, 0);
        chk($sformatf("v%0d_no_stall", i), {31'd0, mem_stall_MEM}, 0);
      end else begin
        chk($sformatf("v%0d_req", i), {31'd0, bus_req}, 1);
        chk($sformatf("v%0d_stall_req", i), {31'd0, mem_stall_MEM}, 1);
        chk($sformatf("v%0d_we", i), {31'd0, bus_we}, {31'd0, v[i].st});
        chk($sformatf("v%0d_addr", i), bus_addr, v[i].addr & 32'hFFFFFFFC);
        chk($sformatf("v%0d_be", i), {28'd0, bus_be}, {28'd0, v[i].be});
        chk($sformatf("v%0d_wdata", i), bus_wdata, v[i].ewd);
        bus_ack = 1; bus_rdata = v[i].rd;
        step;
        bus_ack = 0;
        chk($sformatf("v%0d_stall_done", i), {31'd0, mem_stall_MEM}, 0);
        chk($sformatf("v%0d_req_done", i), {31'd0, bus_req}, 0);
        chk($sformatf("v%0d_rdata", i), rdata_MEM, v[i].erd);
      end
      load_MEM = 0; store_MEM = 0;
      step;
    end
    load_MEM = 1; addr_MEM = 32'h500; size_MEM = 2'd2; sign_MEM = 0;
    step;
    n = 0;
    for (int i = 0; i < 40 && bus_req; i++) begin
      n++;
      step;
    end
    chk("to_req_cycles", n, 16);
    chk("to_bus_err", {31'd0, bus_err_MEM}, 1);
    chk("to_rdata", rdata_MEM, 0);
    chk("to_stall", {31'd0, mem_stall_MEM}, 0);
    load_MEM = 0;
    step;
    chk("to_err_clear", {31'd0, bus_err_MEM}, 0);
    store_MEM = 1; addr_MEM = 32'h202; wdata_MEM = 32'h0000ABCD; size_MEM = 2'd1;
    #1;
    n = 0; ok = 1;
    for (int i = 0; i < 20 && mem_stall_MEM; i++) begin
      n++;
      if (i > 0) ok &= bus_req && bus_we && bus_be == 4'b1100 && bus_wdata == 32'hABCDABCD && bus_addr == 32'h200;
      bus_ack = (i == 5);
      step;
    end
    bus_ack = 0;
    chk("hs_stall_cycles", n, 6);
    chk("hs_stable", {31'd0, ok}, 1);
    chk("hs_rdata", rdata_MEM, 0);
    store_MEM = 0;
    step;
    load_MEM = 1; addr_MEM = 32'h600; size_MEM = 2'd2;
    step;
    chk("rs_req", {31'd0, bus_req}, 1);
    reset = 1;
    #2;
    chk("rs_req_async", {31'd0, bus_req}, 0);
    load_MEM = 0;
    step;
    reset = 0;
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    step;
    bus_ack = 0;
    step;
    chk("rs_req_after", {31'd0, bus_req}, 0);
    chk("rs_rdata", rdata_MEM, 0);
    chk("rs_bus_err", {31'd0, bus_err_MEM}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
